// File: rtl/rom_load_ctrl.sv
// ROM download controller: routes HPS download bytes to the game core ROM,
// title-number and DIP registers, judges ROM completeness and sequences the
// core reset around each download session.
module rom_load_ctrl #(
  parameter int unsigned ROM_SIZE = 114688,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        DL_EN,
  input  logic        DL_WR,
  input  logic [7:0]  DL_INDEX,
  input  logic [24:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  output logic        ROM_WE,
  output logic [16:0] ROM_AD,
  output logic [7:0]  ROM_DT,
  output logic [3:0]  TNO,
  output logic [23:0] SW,
  output logic        CORE_RST,
  output logic        LOAD_OK,
  output logic        LOAD_ERR
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic [24:0] ROM_SIZE_ADDR = 25'(ROM_SIZE);
  localparam logic [17:0] ROM_SIZE_CNT  = 18'(ROM_SIZE);
  localparam logic [7:0]  HOLD_INIT     = 8'(RST_HOLD - 1);

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Declaration initialisers give the power-up state; RESET deliberately
  // leaves the title, DIP and result registers alone.
  logic [1:0]  state_q    = ST_BOOT;
  logic [7:0]  hold_cnt_q = 8'd0;
  logic [17:0] sess_cnt_q = 18'd0;
  logic        sess_ovf_q = 1'b0;
  logic        sess_rom_q = 1'b0;
  logic        rom_we_q   = 1'b0;
  logic [16:0] rom_ad_q   = 17'd0;
  logic [7:0]  rom_dt_q   = 8'd0;
  logic [3:0]  tno_q      = 4'd0;
  logic [23:0] sw_q       = 24'd0;
  logic        load_ok_q  = 1'b0;
  logic        load_err_q = 1'b0;

  logic        accept;
  logic        wr_rom;
  logic        in_range;
  logic        load_entry;
  logic        load_exit;
  logic        sess_good;
  logic [17:0] cnt_base;
  logic        ovf_base;
  logic        rom_base;

  // Write qualification and session boundary decode
  always_comb begin
    accept     = DL_WR & DL_EN & ~RESET;
    wr_rom     = accept && (DL_INDEX == IDX_ROM);
    in_range   = DL_ADDR < ROM_SIZE_ADDR;
    load_entry = ~RESET & DL_EN & (state_q != ST_LOAD);
    load_exit  = ~RESET & ~DL_EN & (state_q == ST_LOAD);
    sess_good  = (sess_cnt_q == ROM_SIZE_CNT) && !sess_ovf_q;
    // A write in the LOAD entry cycle already belongs to the new session.
    cnt_base   = load_entry ? 18'd0 : sess_cnt_q;
    ovf_base   = load_entry ? 1'b0 : sess_ovf_q;
    rom_base   = load_entry ? 1'b0 : sess_rom_q;
  end

  // Session FSM and core-reset stretch counter
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q    <= load_ok_q ? ST_HOLD : ST_BOOT;
      hold_cnt_q <= HOLD_INIT;
    end else begin
      case (state_q)
        ST_BOOT, ST_RUN: begin
          if (DL_EN) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!DL_EN) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_INIT;
          end
        end
        ST_HOLD: begin
          if (DL_EN) begin
            state_q <= ST_LOAD;
          end else if (hold_cnt_q == 8'd0) begin
            state_q <= ST_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  // Session statistics: saturating byte count, overflow and ROM-activity flags
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sess_cnt_q <= 18'd0;
      sess_ovf_q <= 1'b0;
      sess_rom_q <= 1'b0;
    end else begin
      if (wr_rom && in_range && (cnt_base < ROM_SIZE_CNT)) begin
        sess_cnt_q <= cnt_base + 18'd1;
      end else begin
        sess_cnt_q <= cnt_base;
      end
      sess_ovf_q <= ovf_base | (wr_rom & ~in_range);
      sess_rom_q <= rom_base | wr_rom;
    end
  end

  // Result flags, judged once at the end of a session that touched the ROM
  always_ff @(posedge MCLK) begin
    if (load_exit && sess_rom_q) begin
      load_ok_q  <= sess_good;
      load_err_q <= ~sess_good;
    end
  end

  // ROM write port: one registered pulse per in-range byte, address/data held
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      rom_we_q <= 1'b0;
    end else begin
      rom_we_q <= wr_rom & in_range;
    end
    if (wr_rom && in_range) begin
      rom_ad_q <= DL_ADDR[16:0];
      rom_dt_q <= DL_DATA;
    end
  end

  // Title number and DIP byte registers
  always_ff @(posedge MCLK) begin
    if (accept && (DL_INDEX == IDX_TNO)) begin
      tno_q <= DL_DATA[3:0];
    end
    if (accept && (DL_INDEX == IDX_DIP) && (DL_ADDR < 25'd3)) begin
      case (DL_ADDR[1:0])
        2'd0:    sw_q[7:0]   <= DL_DATA;
        2'd1:    sw_q[15:8]  <= DL_DATA;
        default: sw_q[23:16] <= DL_DATA;
      endcase
    end
  end

  assign ROM_WE   = rom_we_q;
  assign ROM_AD   = rom_ad_q;
  assign ROM_DT   = rom_dt_q;
  assign TNO      = tno_q;
  assign SW       = sw_q;
  assign CORE_RST = (state_q != ST_RUN);
  assign LOAD_OK  = load_ok_q;
  assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomised and directed bench for rom_load_ctrl against a session-level
// reference model.
module tb_rom_load_ctrl;

  localparam int unsigned ROM_SIZE = 8;
  localparam int unsigned RST_HOLD = 4;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DL_EN = 1'b0;
  logic        DL_WR = 1'b0;
  logic [7:0]  DL_INDEX = 8'd0;
  logic [24:0] DL_ADDR = 25'd0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        ROM_WE;
  logic [16:0] ROM_AD;
  logic [7:0]  ROM_DT;
  logic [3:0]  TNO;
  logic [23:0] SW;
  logic        CORE_RST;
  logic        LOAD_OK;
  logic        LOAD_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  rom_load_ctrl #(
    .ROM_SIZE(ROM_SIZE),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .MCLK    (MCLK),
    .RESET   (RESET),
    .DL_EN   (DL_EN),
    .DL_WR   (DL_WR),
    .DL_INDEX(DL_INDEX),
    .DL_ADDR (DL_ADDR),
    .DL_DATA (DL_DATA),
    .ROM_WE  (ROM_WE),
    .ROM_AD  (ROM_AD),
    .ROM_DT  (ROM_DT),
    .TNO     (TNO),
    .SW      (SW),
    .CORE_RST(CORE_RST),
    .LOAD_OK (LOAD_OK),
    .LOAD_ERR(LOAD_ERR)
  );

  always #5 MCLK = ~MCLK;

  // Reference model: session bookkeeping plus "cycles left before core runs"
  bit          m_in_sess = 1'b0;
  bit          m_running = 1'b0;
  int          m_left    = 0;
  int          m_cnt     = 0;
  bit          m_ovf     = 1'b0;
  bit          m_had_rom = 1'b0;
  bit          m_we      = 1'b0;
  logic [16:0] m_ad      = '0;
  logic [7:0]  m_dt      = '0;
  logic [3:0]  m_tno     = '0;
  logic [7:0]  m_sw [3]  = '{8'd0, 8'd0, 8'd0};
  bit          m_ok      = 1'b0;
  bit          m_err     = 1'b0;
  int          cyc       = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit wr, input int idx,
                            input int addr, input logic [7:0] data);
    m_we = 1'b0;
    if (rst) begin
      m_in_sess = 1'b0;
      m_running = 1'b0;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_had_rom = 1'b0;
      m_left = m_ok ? RST_HOLD : 0;
      return;
    end
    if (en) begin
      if (!m_in_sess) begin
        m_in_sess = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_had_rom = 1'b0;
      end
      m_running = 1'b0;
      m_left = 0;
      if (wr) begin
        if (idx == 0) begin
          m_had_rom = 1'b1;
          if (addr < int'(ROM_SIZE)) begin
            m_we = 1'b1;
            m_ad = 17'(addr);
            m_dt = data;
            if (m_cnt < int'(ROM_SIZE)) m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end else if (idx == 1) begin
          m_tno = data[3:0];
        end else if (idx == 254 && addr < 3) begin
          m_sw[addr] = data;
        end
      end
    end else if (m_in_sess) begin
      m_in_sess = 1'b0;
      m_left = RST_HOLD;
      if (m_had_rom) begin
        m_ok  = (m_cnt == int'(ROM_SIZE)) && !m_ovf;
        m_err = !m_ok;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_running = 1'b1;
    end
  endtask

  task automatic check_all();
    check_val("rom_we", 32'(ROM_WE), 32'(m_we));
    check_val("rom_ad", 32'(ROM_AD), 32'(m_ad));
    check_val("rom_dt", 32'(ROM_DT), 32'(m_dt));
    check_val("core_rst", 32'(CORE_RST), 32'(!m_running));
    check_val("tno", 32'(TNO), 32'(m_tno));
    check_val("sw", 32'(SW), 32'({m_sw[2], m_sw[1], m_sw[0]}));
    check_val("load_ok", 32'(LOAD_OK), 32'(m_ok));
    check_val("load_err", 32'(LOAD_ERR), 32'(m_err));
  endtask

  // One clock: drive on the falling edge, model the rising edge, check 1 ns later
  task automatic step(input bit rst, input bit en, input bit wr, input int idx,
                      input int addr, input logic [7:0] data);
    @(negedge MCLK);
    RESET    = rst;
    DL_EN    = en;
    DL_WR    = wr;
    DL_INDEX = 8'(idx);
    DL_ADDR  = 25'(addr);
    DL_DATA  = data;
    @(posedge MCLK);
    model_edge(rst, en, wr, idx, addr, data);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
  endtask

  // Session of n back-to-back writes to consecutive addresses, data = addr ^ xr
  task automatic session(input int idx, input int first, input int n, input logic [7:0] xr);
    step(1'b0, 1'b1, 1'b0, idx, 0, 8'h00);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, idx, first + i, 8'(first + i) ^ xr);
  endtask

  initial begin
    int rom_pulses;
    #1;
    check_all();

    // No download: core stays in reset, no ROM writes
    idle(20);
    check_val("boot_core_rst", 32'(CORE_RST), 32'd1);

    // Complete 8-byte image, then reset stretch of exactly RST_HOLD cycles
    session(0, 0, 8, 8'h00);
    step(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    check_val("full_ok", 32'(LOAD_OK), 32'd1);
    check_val("full_err", 32'(LOAD_ERR), 32'd0);
    idle(RST_HOLD - 1);
    check_val("stretch_hi", 32'(CORE_RST), 32'd1);
    idle(1);
    check_val("stretch_lo", 32'(CORE_RST), 32'd0);
    idle(3);

    // Short image
    session(0, 0, 6, 8'h5A);
    idle(8);
    check_val("short_err", 32'(LOAD_ERR), 32'd1);

    // Nine bytes with the last one out of range: only eight pulses
    rom_pulses = 0;
    step(1'b0, 1'b1, 1'b0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 0, i, 8'(i));
      rom_pulses += int'(ROM_WE);
    end
    step(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    rom_pulses += int'(ROM_WE);
    check_val("ovf_pulses", 32'(rom_pulses), 32'd8);
    check_val("ovf_err", 32'(LOAD_ERR), 32'd1);
    idle(6);

    // Good image, then title number and DIP sessions leave LOAD_OK alone
    session(0, 0, 8, 8'h00);
    idle(6);
    step(1'b0, 1'b1, 1'b1, 1, 0, 8'h13);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 254, 0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 254, 0, 8'hAA);
    step(1'b0, 1'b1, 1'b1, 254, 1, 8'hBB);
    step(1'b0, 1'b1, 1'b1, 254, 2, 8'hCC);
    step(1'b0, 1'b1, 1'b1, 254, 3, 8'hDD);
    idle(6);
    check_val("tno_3", 32'(TNO), 32'h3);
    check_val("sw_ccbbaa", 32'(SW), 32'h00CC_BBAA);
    check_val("ok_kept", 32'(LOAD_OK), 32'd1);

    // RESET in RUN after a good load restarts the stretch
    step(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
    check_val("rst_core", 32'(CORE_RST), 32'd1);
    idle(RST_HOLD);
    check_val("rst_run", 32'(CORE_RST), 32'd0);
    check_val("rst_tno", 32'(TNO), 32'h3);

    // RESET mid-session restarts the byte count
    session(0, 0, 4, 8'h00);
    step(1'b1, 1'b1, 1'b0, 0, 0, 8'h00);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b1, 1'b1, 0, i, 8'(i));
    idle(8);
    check_val("abort_err", 32'(LOAD_ERR), 32'd1);
    check_val("abort_ok", 32'(LOAD_OK), 32'd0);

    // Randomised sessions: mixed indices, gaps, out-of-range addresses, resets
    for (int s = 0; s < 60; s++) begin
      int kind;
      int nw;
      kind = int'($urandom_range(0, 9));
      nw   = int'($urandom_range(0, 12));
      if (kind < 3) begin
        session(0, 0, 8, 8'($urandom));
      end else begin
        step(1'b0, 1'b1, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < nw; i++) begin
          int r;
          int idx;
          r   = int'($urandom_range(0, 9));
          idx = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 254 : 9;
          step(($urandom_range(0, 39) == 0), 1'b1, ($urandom_range(0, 3) != 0), idx,
               int'($urandom_range(0, 10)), 8'($urandom));
        end
      end
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        step(($urandom_range(0, 29) == 0), 1'b0, ($urandom_range(0, 1) == 1), 0,
             int'($urandom_range(0, 7)), 8'($urandom));
      end
    end
    idle(RST_HOLD + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
